// File: rtl/cplx_dot_mac_pkg.sv
// Shared constants, phase encoding and FSM state type for the complex dot-product MAC.
// The macros are the single source of truth for operand geometry and phase encoding.
`ifndef CPLX_DOT_MAC_DEFS
`define CPLX_DOT_MAC_DEFS
`define WORD_LEN 16
`define MATRIX_DIM 4
`define ACC_LEN (2*`WORD_LEN+$clog2(`MATRIX_DIM)+1)
`define REAL_SET 1'b0
`define IMAG_SET (~`REAL_SET)
`endif

package cplx_dot_mac_pkg;

  localparam int DEF_WORD_LEN   = `WORD_LEN;
  localparam int DEF_MATRIX_DIM = `MATRIX_DIM;
  localparam int DEF_ACC_LEN    = `ACC_LEN;

  localparam logic REAL_SET = `REAL_SET;
  localparam logic IMAG_SET = `IMAG_SET;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_REAL = 2'd1,
    FSM_IMAG = 2'd2,
    FSM_OUT  = 2'd3
  } fsm_e;

  // Element index width; a single-element row still needs one bit of counter.
  function automatic int idx_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/cplx_mac_lane.sv
// Combinational product term for one element: a*b - c*d in the real phase,
// a*b + c*d in the imaginary phase, sign-extended to the accumulator width.
module cplx_mac_lane
  import cplx_dot_mac_pkg::*;
#(
  parameter int WORD_LEN   = DEF_WORD_LEN,
  parameter int MATRIX_DIM = DEF_MATRIX_DIM,
  parameter int ACC_LEN    = DEF_ACC_LEN,
  parameter int IDX_W      = idx_width(DEF_MATRIX_DIM)
) (
  input  logic [IDX_W-1:0]               idx_i,
  input  logic                           phase_i,
  input  logic [WORD_LEN*MATRIX_DIM-1:0] mx_1_i,
  input  logic [WORD_LEN*MATRIX_DIM-1:0] mx_2_i,
  input  logic [WORD_LEN*MATRIX_DIM-1:0] my_1_i,
  input  logic [WORD_LEN*MATRIX_DIM-1:0] my_2_i,
  output logic signed [ACC_LEN-1:0]      term_o
);

  localparam int PROD_W = 2 * WORD_LEN;
  localparam int EXT_W  = ACC_LEN - PROD_W;

  logic signed [WORD_LEN-1:0] mx1_e [MATRIX_DIM];
  logic signed [WORD_LEN-1:0] mx2_e [MATRIX_DIM];
  logic signed [WORD_LEN-1:0] my1_e [MATRIX_DIM];
  logic signed [WORD_LEN-1:0] my2_e [MATRIX_DIM];

  for (genvar i = 0; i < MATRIX_DIM; i++) begin : g_unpack
    assign mx1_e[i] = mx_1_i[i*WORD_LEN +: WORD_LEN];
    assign mx2_e[i] = mx_2_i[i*WORD_LEN +: WORD_LEN];
    assign my1_e[i] = my_1_i[i*WORD_LEN +: WORD_LEN];
    assign my2_e[i] = my_2_i[i*WORD_LEN +: WORD_LEN];
  end

  logic signed [WORD_LEN-1:0] a_sel;
  logic signed [WORD_LEN-1:0] b_sel;
  logic signed [WORD_LEN-1:0] c_sel;
  logic signed [WORD_LEN-1:0] d_sel;
  logic signed [PROD_W-1:0]   prod_x;
  logic signed [PROD_W-1:0]   prod_y;
  logic signed [ACC_LEN-1:0]  ext_x;
  logic signed [ACC_LEN-1:0]  ext_y;

  always_comb begin
    a_sel  = mx1_e[idx_i];
    b_sel  = mx2_e[idx_i];
    c_sel  = my1_e[idx_i];
    d_sel  = my2_e[idx_i];
    prod_x = PROD_W'(a_sel) * PROD_W'(b_sel);
    prod_y = PROD_W'(c_sel) * PROD_W'(d_sel);
    // Full-precision products widened before the add so the sum cannot wrap.
    ext_x  = {{EXT_W{prod_x[PROD_W-1]}}, prod_x};
    ext_y  = {{EXT_W{prod_y[PROD_W-1]}}, prod_y};
    if (phase_i == IMAG_SET) begin
      term_o = ext_x + ext_y;
    end else begin
      term_o = ext_x - ext_y;
    end
  end

endmodule

// File: rtl/cplx_dot_mac.sv
// Serial complex dot product: one element per clock, real phase then imaginary phase,
// result held under valid/ready until taken; start is only honoured in IDLE.
module cplx_dot_mac
  import cplx_dot_mac_pkg::*;
#(
  parameter int WORD_LEN   = DEF_WORD_LEN,
  parameter int MATRIX_DIM = DEF_MATRIX_DIM,
  parameter int ACC_LEN    = 2*WORD_LEN + $clog2(MATRIX_DIM) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           state,
  output logic                           busy,
  input  logic [WORD_LEN*MATRIX_DIM-1:0] MX_1,
  input  logic [WORD_LEN*MATRIX_DIM-1:0] MX_2,
  input  logic [WORD_LEN*MATRIX_DIM-1:0] MY_1,
  input  logic [WORD_LEN*MATRIX_DIM-1:0] MY_2,
  output logic signed [ACC_LEN-1:0]      res_re,
  output logic signed [ACC_LEN-1:0]      res_im,
  output logic                           res_valid,
  input  logic                           res_ready
);

  localparam int              IDX_W    = idx_width(MATRIX_DIM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MATRIX_DIM - 1);

  fsm_e                      fsm_q, fsm_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_LEN-1:0] acc_q, acc_d;
  logic signed [ACC_LEN-1:0] re_q, re_d;
  logic signed [ACC_LEN-1:0] im_q, im_d;
  logic                      phase_q, phase_d;
  logic                      busy_q, busy_d;
  logic                      valid_q, valid_d;

  logic signed [ACC_LEN-1:0] term;
  logic signed [ACC_LEN-1:0] sum;

  // The select stage reacts combinationally to phase_q, so the term below
  // always belongs to the phase currently being accumulated.
  cplx_mac_lane #(
    .WORD_LEN   (WORD_LEN),
    .MATRIX_DIM (MATRIX_DIM),
    .ACC_LEN    (ACC_LEN),
    .IDX_W      (IDX_W)
  ) u_lane (
    .idx_i   (idx_q),
    .phase_i (phase_q),
    .mx_1_i  (MX_1),
    .mx_2_i  (MX_2),
    .my_1_i  (MY_1),
    .my_2_i  (MY_2),
    .term_o  (term)
  );

  assign sum = acc_q + term;

  always_comb begin
    fsm_d   = fsm_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    re_d    = re_q;
    im_d    = im_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    unique case (fsm_q)
      FSM_IDLE: begin
        if (start) begin
          fsm_d   = FSM_REAL;
          idx_d   = '0;
          acc_d   = '0;
          phase_d = REAL_SET;
          busy_d  = 1'b1;
        end
      end
      FSM_REAL: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          re_d    = sum;
          acc_d   = '0;
          idx_d   = '0;
          phase_d = IMAG_SET;
          fsm_d   = FSM_IMAG;
        end
      end
      FSM_IMAG: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          im_d    = sum;
          acc_d   = '0;
          idx_d   = '0;
          phase_d = REAL_SET;
          valid_d = 1'b1;
          fsm_d   = FSM_OUT;
        end
      end
      FSM_OUT: begin
        // A start coinciding with the handshake is dropped; IDLE must see it.
        if (res_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          fsm_d   = FSM_IDLE;
        end
      end
      default: begin
        fsm_d = FSM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= FSM_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
      phase_q <= REAL_SET;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      re_q    <= re_d;
      im_q    <= im_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign state     = phase_q;
  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign res_re    = re_q;
  assign res_im    = im_q;

endmodule

// File: tb/tb_cplx_dot_mac.sv
// Directed bench for cplx_dot_mac with a behavioural operand-select stage in front of it.
module tb_cplx_dot_mac;
  import cplx_dot_mac_pkg::*;

  localparam int W  = DEF_WORD_LEN;
  localparam int D  = DEF_MATRIX_DIM;
  localparam int A  = DEF_ACC_LEN;
  localparam int VW = W * D;

  logic clk = 1'b0;
  logic rst_n, start, res_ready;
  logic state, busy, res_valid;
  logic [VW-1:0] mx_1, mx_2, my_1, my_2;
  logic [VW-1:0] br1, br2, bi1, bi2;
  logic signed [A-1:0] res_re, res_im;

  int checks   = 0;
  int failures = 0;

  localparam logic signed [A-1:0] TWO_POW_33 = 35'sh200000000;

  always #5 clk = ~clk;

  // Operand-select stage: (br1 + j*bi1) * (br2 + j*bi2), per element.
  always_comb begin
    mx_1 = br1;
    my_1 = bi1;
    if (state == IMAG_SET) begin
      mx_2 = bi2;
      my_2 = br2;
    end else begin
      mx_2 = br2;
      my_2 = bi2;
    end
  end

  cplx_dot_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .state     (state),
    .busy      (busy),
    .MX_1      (mx_1),
    .MX_2      (mx_2),
    .MY_1      (my_1),
    .MY_2      (my_2),
    .res_re    (res_re),
    .res_im    (res_im),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  function automatic logic [VW-1:0] row(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  task automatic load_scn1();
    br1 = row(1, 2, 3, 4);
    br2 = row(1, 1, 1, 1);
    bi1 = '0;
    bi2 = '0;
  endtask

  task automatic load_scn2();
    br1 = row(1, 0, 0, 0);
    bi1 = row(2, 0, 0, 0);
    br2 = row(3, 0, 0, 0);
    bi2 = row(4, 0, 0, 0);
  endtask

  task automatic load_scn3();
    br1 = row(-32768, -32768, -32768, -32768);
    br2 = br1;
    bi1 = br1;
    bi2 = br1;
  endtask

  // All tasks enter and leave just after a falling edge.
  // On return the acceptance edge has passed and the bench is in cycle 1.
  task automatic start_op();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (res_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
    br1 = '0; br2 = '0; bi1 = '0; bi2 = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (state !== REAL_SET) begin failures++; $display("FAIL rst_state got=%0b exp=%0b", state, REAL_SET); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", res_valid); end
    checks++; if (res_re !== '0) begin failures++; $display("FAIL rst_re got=%0d exp=0", res_re); end
    checks++; if (res_im !== '0) begin failures++; $display("FAIL rst_im got=%0d exp=0", res_im); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic exp_state;
    load_scn1();
    start_op();
    for (int c = 1; c <= 9; c++) begin
      exp_state = (c >= 5 && c <= 8) ? IMAG_SET : REAL_SET;
      checks++; if (state !== exp_state) begin failures++; $display("FAIL lat_state c=%0d got=%0b exp=%0b", c, state, exp_state); end
      checks++; if (res_valid !== (c == 9)) begin failures++; $display("FAIL lat_valid c=%0d got=%0b exp=%0b", c, res_valid, (c == 9)); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lat_busy c=%0d got=%0b exp=1", c, busy); end
      if (c < 9) @(negedge clk);
    end
    checks++; if (res_re !== A'(10)) begin failures++; $display("FAIL scn1_re got=%0d exp=10", res_re); end
    checks++; if (res_im !== '0) begin failures++; $display("FAIL scn1_im got=%0d exp=0", res_im); end
    handshake();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL scn1_valid_after got=%0b exp=0", res_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL scn1_busy_after got=%0b exp=0", busy); end
  endtask

  task automatic test_products();
    int lat;
    load_scn2();
    start_op();
    wait_valid(lat);
    checks++; if (lat != 9) begin failures++; $display("FAIL scn2_lat got=%0d exp=9", lat); end
    checks++; if (res_re !== -A'(5)) begin failures++; $display("FAIL scn2_re got=%0d exp=-5", res_re); end
    checks++; if (res_im !== A'(10)) begin failures++; $display("FAIL scn2_im got=%0d exp=10", res_im); end
    handshake();
    load_scn3();
    start_op();
    wait_valid(lat);
    checks++; if (lat != 9) begin failures++; $display("FAIL scn3_lat got=%0d exp=9", lat); end
    checks++; if (res_re !== '0) begin failures++; $display("FAIL scn3_re got=%0d exp=0", res_re); end
    checks++; if (res_im !== TWO_POW_33) begin failures++; $display("FAIL scn3_im got=%0d exp=%0d", res_im, TWO_POW_33); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    load_scn1();
    start_op();
    wait_valid(lat);
    checks++; if (lat != 9) begin failures++; $display("FAIL bp_lat got=%0d exp=9", lat); end
    for (int c = 9; c <= 13; c++) begin
      checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c=%0d got=%0b exp=1", c, res_valid); end
      checks++; if (res_re !== A'(10)) begin failures++; $display("FAIL bp_re c=%0d got=%0d exp=10", c, res_re); end
      checks++; if (res_im !== '0) begin failures++; $display("FAIL bp_im c=%0d got=%0d exp=0", c, res_im); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy c=%0d got=%0b exp=1", c, busy); end
      start = (c == 11);
      @(negedge clk);
    end
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_c14 got=%0b exp=1", res_valid); end
    handshake();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_c15 got=%0b exp=0", res_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy_c15 got=%0b exp=0", busy); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_start_ignored busy got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic seen_valid;
    load_scn1();
    start_op();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (state !== REAL_SET) begin failures++; $display("FAIL abort_state got=%0b exp=%0b", state, REAL_SET); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%0b exp=0", res_valid); end
    checks++; if (res_re !== '0) begin failures++; $display("FAIL abort_re got=%0d exp=0", res_re); end
    checks++; if (res_im !== '0) begin failures++; $display("FAIL abort_im got=%0d exp=0", res_im); end
    seen_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      seen_valid |= res_valid;
      @(negedge clk);
    end
    checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL abort_no_valid got=%0b exp=0", seen_valid); end
    load_scn2();
    start_op();
    wait_valid(lat);
    checks++; if (lat != 9) begin failures++; $display("FAIL abort_restart_lat got=%0d exp=9", lat); end
    checks++; if (res_re !== -A'(5)) begin failures++; $display("FAIL abort_restart_re got=%0d exp=-5", res_re); end
    checks++; if (res_im !== A'(10)) begin failures++; $display("FAIL abort_restart_im got=%0d exp=10", res_im); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    load_scn2();
    start_op();
    wait_valid(lat);
    checks++; if (lat != 9) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=9", lat); end
    checks++; if (res_re !== -A'(5)) begin failures++; $display("FAIL b2b_first_re got=%0d exp=-5", res_re); end
    handshake();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_valid got=%0b exp=0", res_valid); end
    checks++; if (res_re !== -A'(5)) begin failures++; $display("FAIL b2b_held_re got=%0d exp=-5", res_re); end
    checks++; if (res_im !== A'(10)) begin failures++; $display("FAIL b2b_held_im got=%0d exp=10", res_im); end
    load_scn3();
    start_op();
    wait_valid(lat);
    checks++; if (lat != 9) begin failures++; $display("FAIL b2b_second_lat got=%0d exp=9", lat); end
    checks++; if (res_re !== '0) begin failures++; $display("FAIL b2b_second_re got=%0d exp=0", res_re); end
    checks++; if (res_im !== TWO_POW_33) begin failures++; $display("FAIL b2b_second_im got=%0d exp=%0d", res_im, TWO_POW_33); end
    handshake();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_products();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
